data_mem_arbiter: RTL and testbench

- Shares one data_memory port (req/gnt/rvalid protocol) between NUM_REQ requesters, e.g. the core LSU and the trace unit.
- Round-robin arbitration with at most one outstanding transaction.
- Forwards the winner's address phase and routes the response phase (rvalid/rdata/err) back to that winner only.
- Sits between the requesters and data_memory in the system testbench and in the FPGA top.

---
 rtl/data_mem_arbiter_pkg.sv | 23 ++
 rtl/data_mem_rr_picker.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t : IDLE / ADDR / RESP transaction states
//   owner_t     : owner index type for the default requester count
//   idx_width() : index width helper for any requester count
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_NUM_REQ        = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OWNER_W = idx_width(DEFAULT_NUM_REQ);
  typedef logic [OWNER_W-1:0] owner_t;

endpackage

// File: rtl/data_mem_rr_picker.sv
// data_mem_rr_picker: combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : priority pointer (highest-priority index)
//   o_idx   : first requesting index at or after i_ptr, wrapping
//   o_valid : at least one request present
module data_mem_rr_picker
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_hi_valid;
  logic             w_lo_valid;

  // Lowest request at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_valid = 1'b0;
    w_lo_valid = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (i_req[j] && !w_lo_valid) begin
        w_lo_idx   = IDX_W'(j);
        w_lo_valid = 1'b1;
      end
      if (i_req[j] && (j >= 32'(i_ptr)) && !w_hi_valid) begin
        w_hi_idx   = IDX_W'(j);
        w_hi_valid = 1'b1;
      end
    end
    o_valid = w_lo_valid;
    o_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of one data_memory port (req/gnt/rvalid)
// between NUM_REQ requesters, one outstanding transaction at a time.
//   clk, rst                      : clock, asynchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i: per-requester address phase
//   gnt_o/rvalid_o/err_o          : per-requester handshake, owner only
//   rdata_o                       : shared read data, qualified by rvalid_o
//   mem_*_o / mem_*_i             : data_memory side
// Optional: define DATA_MEM_ARBITER_TIMEOUT_EN to enable a response watchdog
// that answers with rvalid+err after TIMEOUT_CYCLES cycles in RESP.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ-1:0]                     we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                     gnt_o,
  output logic [NUM_REQ-1:0]                     rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic [NUM_REQ-1:0]                     err_o,
  output logic                                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  input  logic                                   mem_err_i
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("data_mem_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  idx_t       r_owner;
  idx_t       r_ptr;
  idx_t       w_pick_idx;
  idx_t       w_owner_inc;
  logic       w_pick_valid;
  logic       w_timeout;
  logic       w_done;

  data_mem_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_owner_inc = (r_owner == idx_t'(NUM_REQ - 1)) ? '0 : r_owner + idx_t'(1);
  assign w_done      = (r_state == RESP) && (mem_rvalid_i || w_timeout);

`ifdef DATA_MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside RESP, so it always starts from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != RESP) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == RESP) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_valid) begin
        r_owner <= w_pick_idx;
      end
      if (w_done) begin
        r_ptr <= w_owner_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        // Live owner inputs; mem_req_o stays high even if the owner drops req.
        mem_req_o      = 1'b1;
        mem_addr_o     = addr_i[r_owner];
        mem_we_o       = we_i[r_owner];
        mem_be_o       = be_i[r_owner];
        mem_wdata_o    = wdata_i[r_owner];
        gnt_o[r_owner] = mem_gnt_i;
        if (mem_gnt_i) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rvalid_o[r_owner] = mem_rvalid_i;
        err_o[r_owner]    = mem_err_i;
        rdata_o           = mem_rdata_i;
        if (!mem_rvalid_i && w_timeout) begin
          rvalid_o[r_owner] = 1'b1;
          err_o[r_owner]    = 1'b1;
          rdata_o           = '0;
        end
        if (w_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  a_owner_holds_req: assert property (@(posedge clk) disable iff (rst)
    (r_state == ADDR) |-> req_i[r_owner])
    else $error("data_mem_arbiter: owner dropped req_i before gnt");
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed requester stimulus, a data_memory
// stub, and a scoreboard monitor checking routed responses in service order.
module tb_data_mem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned TMO = 16;

  logic clk;
  logic rst;

  logic          q0_req, q1_req;
  logic [AW-1:0] q0_addr, q1_addr;
  logic          q0_we, q1_we;
  logic [BW-1:0] q0_be, q1_be;
  logic [DW-1:0] q0_wd, q1_wd;

  logic [NR-1:0]         req_i;
  logic [NR-1:0][AW-1:0] addr_i;
  logic [NR-1:0]         we_i;
  logic [NR-1:0][BW-1:0] be_i;
  logic [NR-1:0][DW-1:0] wdata_i;
  logic [NR-1:0]         gnt_o, rvalid_o, err_o;
  logic [DW-1:0]         rdata_o;
  logic                  mem_req_o, mem_we_o;
  logic [AW-1:0]         mem_addr_o;
  logic [BW-1:0]         mem_be_o;
  logic [DW-1:0]         mem_wdata_o;
  logic                  mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [DW-1:0]         mem_rdata_i;

  assign req_i     = {q1_req, q0_req};
  assign addr_i    = {q1_addr, q0_addr};
  assign we_i      = {q1_we, q0_we};
  assign be_i      = {q1_be, q0_be};
  assign wdata_i   = {q1_wd, q0_wd};
  assign mem_gnt_i = mem_req_o;

  data_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  typedef struct {
    int unsigned   r;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   gnt_cnt [NR];
  int   gnt_cyc [NR];
  int   rv_cyc  [NR];
  int   rv_total;
  int   mreq_cnt;
  int   mreq_cyc;
  int   stub_lat;
  bit   stub_hang;
  logic [DW-1:0] mem_w [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int unsigned r, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.r = r; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  // data_memory stub: grants immediately, answers stub_lat cycles after gnt.
  // 0xF0 answers with err; 0xFC never answers while stub_hang is set.
  initial begin
    logic          take, pend, perr, s_we;
    logic [AW-1:0] s_a;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wd, pdata, word;
    int            pcnt;
    for (int i = 0; i < 64; i++) mem_w[i] = '0;
    mem_w[0]  = 32'hB000B1E5;
    mem_w[1]  = 32'hB001B1E5;
    mem_w[32] = 32'h33333333;
    pend = 1'b0; perr = 1'b0; pdata = '0; pcnt = 0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(negedge clk);
      take = mem_req_o && mem_gnt_i;
      s_a = mem_addr_o; s_we = mem_we_o; s_be = mem_be_o; s_wd = mem_wdata_o;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
      if (take) begin
        pend = 1'b1; pcnt = stub_lat; perr = 1'b0;
        if (s_we) begin
          word = mem_w[s_a[7:2]];
          for (int b = 0; b < int'(BW); b++) if (s_be[b]) word[8*b +: 8] = s_wd[8*b +: 8];
          mem_w[s_a[7:2]] = word;
          pdata = 32'h11111111;
        end else if (s_a == 8'hF0) begin
          pdata = 32'hEEEEEEEE; perr = 1'b1;
        end else begin
          pdata = mem_w[s_a[7:2]];
        end
        if (stub_hang && s_a == 8'hFC) pend = 1'b0;
      end
      if (pend) begin
        if (pcnt == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = pdata; mem_err_i = perr; pend = 1'b0;
        end else begin
          pcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every rvalid_o and tracks grants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_o) begin
          mreq_cnt++;
          mreq_cyc = cyc;
        end
        if (gnt_o != '0) begin
          chk("gnt_onehot", 64'($countones(gnt_o)), 64'd1);
          for (int r = 0; r < int'(NR); r++) begin
            if (gnt_o[r]) begin
              gnt_cnt[r]++;
              gnt_cyc[r] = cyc;
            end
          end
        end
        if (rvalid_o != '0) begin
          rv_total++;
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'(rvalid_o), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_route", 64'(rvalid_o), 64'(NR'(1) << e.r));
            chk("rsp_data", 64'(rdata_o), 64'(e.data));
            chk("rsp_err", 64'(err_o), e.err ? 64'(NR'(1) << e.r) : 64'd0);
            rv_cyc[e.r] = cyc;
          end
        end
      end
    end
  end

  task automatic do_req(input int unsigned r, input logic [AW-1:0] a, input logic we,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    bit got;
    got = 1'b0;
    if (r == 0) begin
      q0_req = 1'b1; q0_addr = a; q0_we = we; q0_be = be; q0_wd = wd;
    end else begin
      q1_req = 1'b1; q1_addr = a; q1_we = we; q1_be = be; q1_wd = wd;
    end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (gnt_o[r]) got = 1'b1;
    end
    @(posedge clk); #1;
    if (r == 0) q0_req = 1'b0;
    else        q1_req = 1'b0;
    chk($sformatf("gnt_wait_r%0d", r), 64'(got), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata_o), 64'd0);
    chk({tag, "_mem_req"}, 64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
  endtask

  initial begin
    int c0, base0, starve_r0, rv_before;
    rst = 1'b1;
    q0_req = 1'b0; q0_addr = '0; q0_we = 1'b0; q0_be = '0; q0_wd = '0;
    q1_req = 1'b0; q1_addr = '0; q1_we = 1'b0; q1_be = '0; q1_wd = '0;
    stub_lat = 0; stub_hang = 1'b0;
    n_checks = 0; n_errors = 0; rv_total = 0; mreq_cnt = 0; mreq_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    outputs_zero("idle");

    // Single read by requester 0.
    push_exp(0, 32'hB000B1E5, 1'b0);
    c0 = cyc;
    do_req(0, 8'h00, 1'b0, '1, '0);
    drain("single");
    chk("single_gnt0", 64'(gnt_cnt[0]), 64'd1);
    chk("single_gnt1", 64'(gnt_cnt[1]), 64'd0);
    chk("single_mem_req_cycles", 64'(mreq_cnt), 64'd1);
    chk("req_to_mem_req_latency", 64'(mreq_cyc - c0), 64'd1);

    // Contention straight after reset, then 4 more simultaneous pairs.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int p = 0; p < 5; p++) begin
      push_exp(0, 32'hB001B1E5, 1'b0);
      push_exp(1, 32'h33333333, 1'b0);
      fork
        do_req(0, 8'h04, 1'b0, '1, '0);
        do_req(1, 8'h80, 1'b0, '1, '0);
      join
      drain($sformatf("pair%0d", p));
    end

    // Write routing with byte enables, then read back.
    push_exp(1, 32'h11111111, 1'b0);
    do_req(1, 8'h08, 1'b1, 4'b0011, 32'hDEADBEEF);
    drain("write");
    push_exp(0, 32'h0000BEEF, 1'b0);
    do_req(0, 8'h08, 1'b0, '1, '0);
    drain("readback");

    // Error response routed to requester 1 only.
    push_exp(1, 32'hEEEEEEEE, 1'b1);
    do_req(1, 8'hF0, 1'b0, '1, '0);
    drain("err");

    // Starvation: requester 0 back to back, requester 1 raised once.
    base0 = gnt_cnt[0];
    starve_r0 = -1;
    push_exp(0, 32'hB000B1E5, 1'b0);
    push_exp(1, 32'h33333333, 1'b0);
    push_exp(0, 32'hB000B1E5, 1'b0);
    push_exp(0, 32'hB000B1E5, 1'b0);
    fork
      begin
        do_req(0, 8'h00, 1'b0, '1, '0);
        do_req(0, 8'h00, 1'b0, '1, '0);
        do_req(0, 8'h00, 1'b0, '1, '0);
      end
      begin
        @(posedge clk); #1;
        do_req(1, 8'h80, 1'b0, '1, '0);
        starve_r0 = gnt_cnt[0] - base0;
      end
    join
    drain("starve");
    chk("starve_r0_grants_before_r1", 64'(starve_r0), 64'd1);

    // Pointer now at 1: a simultaneous pair serves requester 1 first.
    push_exp(1, 32'h33333333, 1'b0);
    push_exp(0, 32'hB001B1E5, 1'b0);
    fork
      do_req(0, 8'h04, 1'b0, '1, '0);
      do_req(1, 8'h80, 1'b0, '1, '0);
    join
    drain("ptr1_pair");

    // Reset while waiting for the response; the late rvalid must be dropped.
    stub_lat = 4;
    rv_before = rv_total;
    do_req(0, 8'h00, 1'b0, '1, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    outputs_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_late_rvalid", 64'(rv_total - rv_before), 64'd0);
    stub_lat = 0;
    push_exp(0, 32'hB001B1E5, 1'b0);
    do_req(0, 8'h04, 1'b0, '1, '0);
    drain("post_rst");

`ifdef DATA_MEM_ARBITER_TIMEOUT_EN
    // Watchdog answers requester 0, then requester 1 is served.
    stub_hang = 1'b1;
    push_exp(0, 32'h00000000, 1'b1);
    push_exp(1, 32'h33333333, 1'b0);
    fork
      do_req(0, 8'hFC, 1'b0, '1, '0);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_req(1, 8'h80, 1'b0, '1, '0);
      end
    join
    drain("timeout");
    chk("timeout_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'(TMO));
    chk("timeout_r1_after", 64'(gnt_cyc[1] > rv_cyc[0]), 64'd1);
    stub_hang = 1'b0;
`endif

    chk("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
